// File: rtl/apu_codec_link.sv
// Clock-master left-justified codec link: 16-bit mono sample out on both DAC channels, ADC left channel in.
// DAC MSB appears on the frame-start fall event; audio_input updates mid-bit 15; no backpressure (fixed-rate frames).
module apu_codec_link #(
    parameter int unsigned BCLK_HALF = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] audio_output,
    output logic [15:0] audio_input,
    output logic        sample_req,
    output logic        sample_end,
    output logic        aud_bclk,
    output logic        aud_daclrck,
    output logic        aud_adclrck,
    output logic        aud_dacdat,
    input  logic        aud_adcdat
);
    localparam logic [7:0] DIV_LAST = 8'(BCLK_HALF - 1);

    logic [7:0]  div_cnt_q, div_cnt_d;
    logic        bclk_q, bclk_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        lrck_q, lrck_d;
    logic [15:0] dac_sr_q, dac_sr_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] adc_sr_q, adc_sr_d;
    logic [15:0] audio_in_q, audio_in_d;
    logic        req_q, req_d;
    logic        end_q, end_d;

    logic        edge_evt;
    logic        rise_evt;
    logic        fall_evt;
    logic [4:0]  nb;
    logic [15:0] adc_next;

    always_comb begin
        edge_evt   = (div_cnt_q == DIV_LAST);
        rise_evt   = edge_evt && !bclk_q;
        fall_evt   = edge_evt && bclk_q;
        nb         = bit_cnt_q + 5'd1;
        adc_next   = {adc_sr_q[14:0], aud_adcdat};

        div_cnt_d  = edge_evt ? 8'd0 : div_cnt_q + 8'd1;
        bclk_d     = edge_evt ? ~bclk_q : bclk_q;
        bit_cnt_d  = bit_cnt_q;
        lrck_d     = lrck_q;
        dac_sr_d   = dac_sr_q;
        hold_d     = hold_q;
        adc_sr_d   = adc_sr_q;
        audio_in_d = audio_in_q;
        req_d      = 1'b0;
        end_d      = 1'b0;

        // Rising BCLK: capture ADC mid-bit; left channel is bits 0..15.
        if (rise_evt) begin
            if (!bit_cnt_q[4]) begin
                adc_sr_d = adc_next;
            end
            if (bit_cnt_q == 5'd15) begin
                audio_in_d = adc_next;
                end_d      = 1'b1;
            end
            if (bit_cnt_q == 5'd31) begin
                req_d = 1'b1;
            end
        end

        // Falling BCLK: advance bit position; the mixer sample is taken only at frame start
        // and replayed from hold for the right channel.
        if (fall_evt) begin
            bit_cnt_d = nb;
            if (nb == 5'd0) begin
                dac_sr_d = audio_output;
                hold_d   = audio_output;
                lrck_d   = 1'b0;
            end else if (nb == 5'd16) begin
                dac_sr_d = hold_q;
                lrck_d   = 1'b1;
            end else begin
                dac_sr_d = {dac_sr_q[14:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q  <= 8'd0;
            bclk_q     <= 1'b0;
            bit_cnt_q  <= 5'd31;
            lrck_q     <= 1'b0;
            dac_sr_q   <= 16'd0;
            hold_q     <= 16'd0;
            adc_sr_q   <= 16'd0;
            audio_in_q <= 16'd0;
            req_q      <= 1'b0;
            end_q      <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bclk_q     <= bclk_d;
            bit_cnt_q  <= bit_cnt_d;
            lrck_q     <= lrck_d;
            dac_sr_q   <= dac_sr_d;
            hold_q     <= hold_d;
            adc_sr_q   <= adc_sr_d;
            audio_in_q <= audio_in_d;
            req_q      <= req_d;
            end_q      <= end_d;
        end
    end

    assign audio_input = audio_in_q;
    assign sample_req  = req_q;
    assign sample_end  = end_q;
    assign aud_bclk    = bclk_q;
    assign aud_daclrck = lrck_q;
    assign aud_adclrck = lrck_q;
    assign aud_dacdat  = dac_sr_q[15];

endmodule

// File: tb/tb_apu_codec_link.sv
// Bench for apu_codec_link: instance A (BCLK_HALF=2) in loopback with a frame scoreboard,
// instance B (BCLK_HALF=5) with a constant 16'h0001 sample.
`timescale 1ns/1ps
module tb_apu_codec_link;
    localparam int HA = 2;
    localparam int HB = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] aout_a;
    logic [15:0] ain_a, ain_b;
    logic        req_a, end_a, bclk_a, dlr_a, alr_a, dd_a, adc_a;
    logic        req_b, end_b, bclk_b, dlr_b, alr_b, dd_b, adc_b;
    logic [15:0] aout_b;

    assign adc_a  = dd_a;
    assign adc_b  = dd_b;
    assign aout_b = 16'h0001;

    apu_codec_link #(.BCLK_HALF(HA)) u_dut_a (
        .clk(clk), .reset(reset), .audio_output(aout_a), .audio_input(ain_a),
        .sample_req(req_a), .sample_end(end_a), .aud_bclk(bclk_a),
        .aud_daclrck(dlr_a), .aud_adclrck(alr_a), .aud_dacdat(dd_a), .aud_adcdat(adc_a)
    );

    apu_codec_link #(.BCLK_HALF(HB)) u_dut_b (
        .clk(clk), .reset(reset), .audio_output(aout_b), .audio_input(ain_b),
        .sample_req(req_b), .sample_end(end_b), .aud_bclk(bclk_b),
        .aud_daclrck(dlr_b), .aud_adclrck(alr_b), .aud_dacdat(dd_b), .aud_adcdat(adc_b)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release.
    int k;
    always @(posedge clk or posedge reset) begin
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    int n_checks = 0;
    int n_err    = 0;
    logic [15:0] exp_dac[$];
    logic [15:0] exp_adc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (k=%0d t=%0t)", name, act, exp, k, $time);
        end
    endtask

    // {bclk, lrck, sample_req, sample_end} expected kk edges after release.
    function automatic logic [3:0] exp_tim(input int kk, input int h);
        logic b, l, r, e;
        b = ((kk / h) % 2) == 1;
        l = (kk >= 34*h) && (((kk - 34*h) % (64*h)) < 32*h);
        r = (kk >= h) && (((kk - h) % (64*h)) == 0);
        e = (kk >= 33*h) && (((kk - 33*h) % (64*h)) == 0);
        return {b, l, r, e};
    endfunction

    // Instance B carries 16'h0001: DAC high only in bits 15 and 31.
    function automatic logic exp_dd_b(input int kk);
        int n;
        if (kk < 2*HB) return 1'b0;
        n = ((kk - 2*HB) % (64*HB)) / (2*HB);
        return (n == 15) || (n == 31);
    endfunction

    // Monitor: per-cycle timing, DAC deserializer and ADC scoreboard.
    initial begin
        logic        prev_a;
        logic [15:0] word_a;
        logic [3:0]  ta, tb;
        int          n;
        prev_a = 1'b0;
        word_a = 16'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_zero_a", {ain_a, req_a, end_a, bclk_a, dlr_a, alr_a, dd_a}, 32'd0);
                chk("rst_zero_b", {ain_b, req_b, end_b, bclk_b, dlr_b, alr_b, dd_b}, 32'd0);
                prev_a = 1'b0;
            end else begin
                ta = exp_tim(k, HA);
                tb = exp_tim(k, HB);
                chk("timing_a", {bclk_a, dlr_a, req_a, end_a}, ta);
                chk("adclrck_a", alr_a, ta[2]);
                chk("timing_b", {bclk_b, dlr_b, req_b, end_b}, tb);
                chk("adclrck_b", alr_b, tb[2]);
                chk("dacdat_b", dd_b, exp_dd_b(k));
                if (end_b) chk("audio_input_b", ain_b, 16'h0001);
                if (end_a) begin
                    if (exp_adc.size() == 0) begin
                        n_checks++; n_err++;
                        $display("FAIL audio_input_a: sample_end with no frame pending, got %h", ain_a);
                    end else begin
                        chk("audio_input_a", ain_a, exp_adc.pop_front());
                    end
                end
                if (bclk_a && !prev_a && k > 2*HA) begin
                    n = ((k - 3*HA) / (2*HA)) % 32;
                    word_a[15 - (n % 16)] = dd_a;
                    if (n == 15 || n == 31) begin
                        if (exp_dac.size() == 0) begin
                            n_checks++; n_err++;
                            $display("FAIL dac_word_a: word %h with no frame pending", word_a);
                        end else if (n == 15) begin
                            chk("dac_left_a", word_a, exp_dac[0]);
                        end else begin
                            chk("dac_right_a", word_a, exp_dac.pop_front());
                        end
                    end
                end
                prev_a = bclk_a;
            end
        end
    end

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_frame(input logic [15:0] s, input bit ch, input logic [15:0] s2, input bit rst_mid);
        aout_a = s;
        exp_dac.push_back(s);
        exp_adc.push_back(s);
        repeat (HA) @(posedge clk);
        if (ch) begin
            repeat (20) @(posedge clk);
            #1 aout_a = s2;
        end
        if (rst_mid) begin
            repeat (37) @(posedge clk);
            @(negedge clk);
            #1 reset = 1'b1;
            #1;
            chk("async_rst_a", {ain_a, req_a, end_a, bclk_a, dlr_a, alr_a, dd_a}, 32'd0);
            chk("async_rst_b", {ain_b, req_b, end_b, bclk_b, dlr_b, alr_b, dd_b}, 32'd0);
            exp_dac.delete();
            exp_adc.delete();
            repeat (5) @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
        end
    endtask

    localparam int NF = 15;
    logic [15:0] smp[NF];
    logic [15:0] smp2[NF];
    bit          chg[NF];
    bit          rmid[NF];

    initial begin
        bit ok;
        reset  = 1'b1;
        aout_a = 16'h0;
        for (int f = 0; f < NF; f++) begin
            smp[f]  = 16'($urandom);
            smp2[f] = 16'($urandom);
            chg[f]  = ($urandom_range(0, 1) == 1);
            rmid[f] = 1'b0;
        end
        smp[0] = 16'hA5C3; chg[0] = 1'b0;
        smp[1] = 16'hA5C3; chg[1] = 1'b0;
        smp[2] = 16'h1234; chg[2] = 1'b1; smp2[2] = 16'hFFFF;
        smp[3] = 16'hFFFF; chg[3] = 1'b0;
        smp[4] = 16'h8001; chg[4] = 1'b0;
        smp[5] = 16'h7FFE; chg[5] = 1'b0;
        smp[11] = 16'hFFFF; chg[11] = 1'b0; rmid[11] = 1'b1;

        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        ok = 1'b1;
        for (int f = 0; f < NF && ok; f++) begin
            wait_req(ok);
            if (ok) run_frame(smp[f], chg[f], smp2[f], rmid[f]);
        end
        if (ok) wait_req(ok);
        if (!ok) begin
            n_checks++; n_err++;
            $display("FAIL wait_req: sample_req absent for 200 clk, got 0 want 1");
        end else begin
            repeat (2) @(negedge clk);
            chk("dac_queue_drained", exp_dac.size(), 32'd0);
            chk("adc_queue_drained", exp_adc.size(), 32'd0);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apu_codec_link.md
# apu_codec_link

Serial link between the APU sample path and the board audio codec. The block is clock master. It generates the bit clock (BCLK) and the left/right clock (LRCK), and serializes the 16-bit mono mixer sample onto both DAC channels. It deserializes the ADC left channel into `audio_input`. It drives the `sample_req`/`sample_end` handshake that the APU mixer consumes.

## Interface
- `BCLK_HALF`, default 4: clk cycles per BCLK half-period. Legal range is 2..255.
- `clk`  in  1: system clock. The only clock in the block.
- `reset`  in  1: asynchronous, active-high reset.
- `audio_output`  in  16: mono sample from the mixer. Sampled only at frame load points.
- `audio_input`  out  16: last captured ADC left-channel sample.
- `sample_req`  out  1: one-clk pulse requesting the next mixer sample.
- `sample_end`  out  1: one-clk pulse; `audio_input` has been updated that cycle.
- `aud_bclk`  out  1: codec bit clock, clk / (2·BCLK_HALF).
- `aud_daclrck`  out  1: DAC LRCK. 0 = left, 1 = right.
- `aud_adclrck`  out  1: ADC LRCK. Identical to `aud_daclrck`.
- `aud_dacdat`  out  1: DAC serial data, MSB first.
- `aud_adcdat`  in  1: ADC serial data, MSB first.

## Operation
- Format is left-justified: 32 BCLK per frame and 16 bits per channel. The MSB coincides with the LRCK edge.
- Internal state:
  - `div_cnt`, 8 bits: counts 0..BCLK_HALF-1, then wraps.
  - `bit_cnt`, 5 bits: wraps 31→0.
  - `dac_sr`, 16 bits: DAC shift register.
  - `hold`, 16 bits: copy of the sample loaded at frame start.
  - `adc_sr`, 16 bits: ADC shift register.
- Edge events are decoded from `div_cnt` = BCLK_HALF-1:
  - rise event when `aud_bclk` = 0; `aud_bclk` toggles to 1 on the next edge.
  - fall event when `aud_bclk` = 1; `aud_bclk` toggles to 0 on the next edge.
- On a rise event:
  - If `bit_cnt` < 16: `adc_sr` <= {`adc_sr`[14:0], `aud_adcdat`}.
  - If `bit_cnt` = 15: `audio_input` <= {`adc_sr`[14:0], `aud_adcdat`} and `sample_end` <= 1.
  - If `bit_cnt` = 31: `sample_req` <= 1.
- On a fall event, compute nb = `bit_cnt`+1 (mod 32), then `bit_cnt` <= nb and:
  - nb = 0: `dac_sr` <= `audio_output`, `hold` <= `audio_output`, LRCK <= 0.
  - nb = 16: `dac_sr` <= `hold`, LRCK <= 1.
  - otherwise: `dac_sr` <= `dac_sr` << 1.
- `aud_dacdat` = `dac_sr`[15].
- Both channels always carry the same sample value. The ADC right channel is ignored.
- `sample_req` and `sample_end` are cleared on every cycle in which they are not set. Each is high for exactly 1 clk.

## Timing
- Reset values: every output is 0, and all of `div_cnt`, `dac_sr`, `hold`, `adc_sr` are 0. `bit_cnt` resets to 31, so the first fall event opens frame 0.
- Reset asserted mid-frame: all state returns to reset values immediately, without waiting for a clock edge. No partial sample is delivered.
- Event timing after reset release:
  - First rise event: clk edge BCLK_HALF. `sample_req` is high in the cycle after that edge.
  - First fall event: clk edge 2·BCLK_HALF. It loads `audio_output`.
  - Producer lead time: BCLK_HALF clks from `sample_req` to load.
- Frame period: 64·BCLK_HALF clks.
  - `sample_req` occurs once per frame, in bit 31.
  - `sample_end` occurs once per frame, mid-bit 15.
  - `sample_req` and `sample_end` are never high in the same cycle.
- DAC latency: the sample loaded at the frame start appears MSB-first on `aud_dacdat` at once. The last right-channel bit ends 64·BCLK_HALF clks later.
- `audio_output` changes between loads have no effect. A change after frame start reaches the DAC in the next frame, including the right channel.
- `aud_adcdat` is sampled in the cycle of the rise event, i.e. mid-bit. The codec must hold data stable around rising BCLK.
- `aud_dacdat` and LRCK change only on clk edges that follow fall events. BCLK_HALF ≥ 2 guarantees at least 2 clk of setup before rising BCLK.

## Test plan
1. **Reset and period.** Set BCLK_HALF=2 and hold reset for 5 clk, then release.
   - All outputs are 0 during reset.
   - `sample_req` is high only in cycle 2 after release, then every 128 clk.
   - `aud_bclk` toggles every 2 clk.
2. **Serialization.** Hold `audio_output` = 16'hA5C3.
   - `aud_dacdat` bit sequence per frame is 1010_0101_1100_0011 with LRCK=0, then the same 16 bits with LRCK=1.
   - Each bit lasts 4 clk.
3. **Mid-frame change.** Change `audio_output` from 16'h1234 to 16'hFFFF 20 clk after a frame load.
   - The right channel of the current frame still carries 16'h1234.
   - The next frame carries 16'hFFFF on both channels.
4. **Loopback.** Tie `aud_adcdat` to `aud_dacdat` and send samples 16'h8001, then 16'h7FFE.
   - `sample_end` pulses 62 clk after each frame load.
   - `audio_input` equals that frame's sample at each `sample_end`.
5. **Reset mid-frame.** Assert reset at `bit_cnt` = 9 of a frame carrying 16'hFFFF.
   - All outputs drop to 0 asynchronously.
   - After release, timing matches scenario 1 exactly.
6. **Parameter sweep.** Set BCLK_HALF=5 with `audio_output` = 16'h0001.
   - Frame period is 320 clk.
   - `aud_dacdat` is high only during bits 15 and 31, each high for 10 clk.
